// File: rtl/uart_baud_generator.sv
// UART baud-rate generator: fractional divisor, oversampled sample clock,
// per-sample, per-bit and mid-bit strobes, reloads applied at period boundaries.
module uart_baud_generator #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  enable_in,
    input  logic [DIV_WIDTH-1:0]  divisor_in,
    input  logic [FRAC_WIDTH-1:0] frac_in,
    input  logic                  load_in,
    output logic                  bclk_out,
    output logic                  sample_tick_out,
    output logic                  bit_tick_out,
    output logic                  mid_bit_tick_out,
    output logic                  load_pending_out
);
    localparam int unsigned OS_WIDTH = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned N_WIDTH  = DIV_WIDTH + 1;
    localparam logic [OS_WIDTH-1:0] OS_LAST = OS_WIDTH'(OVERSAMPLE - 1);
    localparam logic [OS_WIDTH-1:0] OS_MID  = OS_WIDTH'(OVERSAMPLE / 2 - 1);

    logic [DIV_WIDTH-1:0]  pend_div_q, pend_div_d, act_div_q, act_div_d;
    logic [FRAC_WIDTH-1:0] pend_frac_q, pend_frac_d, act_frac_q, act_frac_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [DIV_WIDTH-1:0]  slot_q, slot_d;
    logic [N_WIDTH-1:0]    n_q, n_d;
    logic [FRAC_WIDTH-1:0] acc_q, acc_d;
    logic [OS_WIDTH-1:0]   os_q, os_d;
    logic                  running_q, running_d;
    logic                  bclk_q, bclk_d, tick_q, tick_d, bit_q, bit_d, mid_q, mid_d;

    logic                  last_slot, period_start, bypass;
    logic [DIV_WIDTH-1:0]  eff_div;
    logic [FRAC_WIDTH-1:0] eff_frac, eff_acc;
    logic [FRAC_WIDTH:0]   sum;
    logic [N_WIDTH-1:0]    half, slot_ext;

    always_comb begin
        pend_div_d  = pend_div_q;
        pend_frac_d = pend_frac_q;
        pend_flag_d = pend_flag_q;
        act_div_d   = act_div_q;
        act_frac_d  = act_frac_q;
        running_d   = 1'b0;
        slot_d      = '0;
        n_d         = '0;
        acc_d       = '0;
        os_d        = '0;
        bclk_d      = 1'b1;
        tick_d      = 1'b0;
        bit_d       = 1'b0;
        mid_d       = 1'b0;
        sum         = '0;
        half        = '0;
        slot_ext    = '0;
        eff_div     = act_div_q;
        eff_frac    = act_frac_q;
        eff_acc     = acc_q;

        last_slot    = running_q && ({1'b0, slot_q} == n_q - N_WIDTH'(1));
        period_start = !running_q || last_slot;
        // A load landing in the last slot feeds straight into the next period.
        bypass       = enable_in && last_slot && load_in;

        if (!enable_in) begin
            if (pend_flag_q) begin
                act_div_d   = pend_div_q;
                act_frac_d  = pend_frac_q;
                pend_flag_d = 1'b0;
            end
        end else begin
            if (bypass) begin
                eff_div  = divisor_in;
                eff_frac = frac_in;
                eff_acc  = '0;
            end else if (period_start && pend_flag_q) begin
                eff_div     = pend_div_q;
                eff_frac    = pend_frac_q;
                eff_acc     = '0;
                pend_flag_d = 1'b0;
            end
            if (period_start) begin
                act_div_d  = eff_div;
                act_frac_d = eff_frac;
            end

            if (tick_q) begin
                os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
            end else begin
                os_d = os_q;
            end

            if (!period_start) begin
                running_d = 1'b1;
                slot_d    = slot_q + 1'b1;
                n_d       = n_q;
                acc_d     = acc_q;
            end else if (eff_div != '0) begin
                sum       = {1'b0, eff_acc} + {1'b0, eff_frac};
                running_d = 1'b1;
                n_d       = {1'b0, eff_div} + N_WIDTH'(sum[FRAC_WIDTH]);
                acc_d     = sum[FRAC_WIDTH-1:0];
            end else begin
                os_d = '0;
            end

            if (running_d) begin
                slot_ext = {1'b0, slot_d};
                half     = (n_d + N_WIDTH'(1)) >> 1;
                bclk_d   = slot_ext < half;
                tick_d   = slot_ext == n_d - N_WIDTH'(1);
                bit_d    = tick_d && (os_d == OS_LAST);
                mid_d    = tick_d && (os_d == OS_MID);
            end
        end

        if (bypass) begin
            pend_flag_d = 1'b0;
        end else if (load_in) begin
            pend_div_d  = divisor_in;
            pend_frac_d = frac_in;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            pend_div_q  <= '0;
            pend_frac_q <= '0;
            pend_flag_q <= 1'b0;
            act_div_q   <= '0;
            act_frac_q  <= '0;
            slot_q      <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            os_q        <= '0;
            running_q   <= 1'b0;
            bclk_q      <= 1'b1;
            tick_q      <= 1'b0;
            bit_q       <= 1'b0;
            mid_q       <= 1'b0;
        end else begin
            pend_div_q  <= pend_div_d;
            pend_frac_q <= pend_frac_d;
            pend_flag_q <= pend_flag_d;
            act_div_q   <= act_div_d;
            act_frac_q  <= act_frac_d;
            slot_q      <= slot_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            os_q        <= os_d;
            running_q   <= running_d;
            bclk_q      <= bclk_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            mid_q       <= mid_d;
        end
    end

    assign bclk_out         = bclk_q;
    assign sample_tick_out  = tick_q;
    assign bit_tick_out     = bit_q;
    assign mid_bit_tick_out = mid_q;
    assign load_pending_out = pend_flag_q;

endmodule

// File: tb/tb_uart_baud_generator.sv
// Directed bench for uart_baud_generator: table of divisor settings with
// expected period lengths, plus sequences for reloads, stalls, disable and reset.
module tb_uart_baud_generator;
    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [15:0] divisor;
    logic [3:0]  frac;
    logic        load;
    logic        bclk, sample_tick, bit_tick, mid_bit_tick, load_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0]     div;
        logic [3:0]      frac;
        logic [0:3][7:0] len;
        logic [0:3][7:0] high;
    } vec_t;

    vec_t vecs [6];

    uart_baud_generator #(
        .DIV_WIDTH (16),
        .FRAC_WIDTH(4),
        .OVERSAMPLE(16)
    ) dut (
        .clk_in          (clk),
        .rstn_in         (rstn),
        .enable_in       (enable),
        .divisor_in      (divisor),
        .frac_in         (frac),
        .load_in         (load),
        .bclk_out        (bclk),
        .sample_tick_out (sample_tick),
        .bit_tick_out    (bit_tick),
        .mid_bit_tick_out(mid_bit_tick),
        .load_pending_out(load_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Disable, load while idle, enable; returns observing slot 0.
    task automatic cfg(input int d, input int f);
        enable  = 1'b0;
        step();
        load    = 1'b1;
        divisor = 16'(d);
        frac    = 4'(f);
        step();
        load    = 1'b0;
        step();
        enable  = 1'b1;
        step();
    endtask

    // Starts on slot 0; returns on slot 0 of the following period.
    task automatic measure(output int len, output int high);
        len  = 0;
        high = 0;
        for (int i = 0; i < 1000; i++) begin
            len++;
            high += int'(bclk);
            if (sample_tick) break;
            step();
        end
        step();
    endtask

    initial begin
        int len, high, cyc, cnt, lows;
        int first_mid, second_mid, first_bit, second_bit;

        vecs[0] = '{div: 16'd4, frac: 4'd0, len: {8'd4, 8'd4, 8'd4, 8'd4},
                    high: {8'd2, 8'd2, 8'd2, 8'd2}};
        vecs[1] = '{div: 16'd5, frac: 4'd0, len: {8'd5, 8'd5, 8'd5, 8'd5},
                    high: {8'd3, 8'd3, 8'd3, 8'd3}};
        vecs[2] = '{div: 16'd3, frac: 4'd8, len: {8'd3, 8'd4, 8'd3, 8'd4},
                    high: {8'd2, 8'd2, 8'd2, 8'd2}};
        vecs[3] = '{div: 16'd1, frac: 4'd0, len: {8'd1, 8'd1, 8'd1, 8'd1},
                    high: {8'd1, 8'd1, 8'd1, 8'd1}};
        vecs[4] = '{div: 16'd2, frac: 4'd4, len: {8'd2, 8'd2, 8'd2, 8'd3},
                    high: {8'd1, 8'd1, 8'd1, 8'd2}};
        vecs[5] = '{div: 16'd7, frac: 4'd15, len: {8'd7, 8'd8, 8'd8, 8'd8},
                    high: {8'd4, 8'd4, 8'd4, 8'd4}};

        rstn    = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        divisor = '0;
        frac    = '0;
        step();
        step();
        check("reset_bclk", int'(bclk), 1);
        check("reset_ticks", int'(sample_tick) + int'(bit_tick) + int'(mid_bit_tick), 0);
        check("reset_pending", int'(load_pending), 0);
        rstn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            cfg(int'(vecs[v].div), int'(vecs[v].frac));
            for (int p = 0; p < 4; p++) begin
                measure(len, high);
                check($sformatf("vec%0d_len%0d", v, p), len, int'(vecs[v].len[p]));
                check($sformatf("vec%0d_high%0d", v, p), high, int'(vecs[v].high[p]));
            end
        end

        // Bit and mid-bit strobes at D=4.
        cfg(4, 0);
        first_mid = -1; second_mid = -1; first_bit = -1; second_bit = -1;
        for (int i = 0; i < 200; i++) begin
            if (mid_bit_tick) begin
                if (first_mid < 0) first_mid = i;
                else if (second_mid < 0) second_mid = i;
            end
            if (bit_tick) begin
                if (first_bit < 0) first_bit = i;
                else if (second_bit < 0) second_bit = i;
            end
            step();
        end
        check("first_mid", first_mid, 31);
        check("first_bit", first_bit, 63);
        check("second_mid", second_mid, 95);
        check("second_bit", second_bit, 127);

        // 100 periods of 3 + 8/16.
        cfg(3, 8);
        cyc = 0;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc++;
            if (sample_tick) cnt++;
            if (cnt == 100) break;
            step();
        end
        check("frac_100_periods", cyc, 350);

        // Reload D=8 in slot 1 of a D=4 period.
        cfg(4, 0);
        step();
        load    = 1'b1;
        divisor = 16'd8;
        frac    = 4'd0;
        step();
        load = 1'b0;
        check("reload_pending_slot2", int'(load_pending), 1);
        step();
        check("reload_old_tick_slot3", int'(sample_tick), 1);
        check("reload_pending_slot3", int'(load_pending), 1);
        step();
        check("reload_pending_cleared", int'(load_pending), 0);
        measure(len, high);
        check("reload_new_len", len, 8);
        check("reload_new_high", high, 4);

        // Load in the last slot applies to the very next period.
        for (int i = 0; i < 7; i++) step();
        check("bypass_last_slot_tick", int'(sample_tick), 1);
        load    = 1'b1;
        divisor = 16'd4;
        step();
        load = 1'b0;
        check("bypass_pending", int'(load_pending), 0);
        measure(len, high);
        check("bypass_len", len, 4);

        // Disable in slot 2 while acc is non-zero; restart must clear acc.
        cfg(6, 8);
        step();
        step();
        enable = 1'b0;
        step();
        check("disable_bclk", int'(bclk), 1);
        check("disable_ticks", int'(sample_tick) + int'(bit_tick) + int'(mid_bit_tick), 0);
        enable = 1'b1;
        step();
        measure(len, high);
        check("reenable_len0", len, 6);
        check("reenable_high0", high, 3);
        measure(len, high);
        check("reenable_len1", len, 7);

        // D=0 stalls regardless of F.
        cfg(0, 8);
        cnt  = 0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            cnt  += int'(sample_tick) + int'(bit_tick) + int'(mid_bit_tick);
            lows += int'(!bclk);
            step();
        end
        check("stall_ticks", cnt, 0);
        check("stall_bclk_low", lows, 0);

        // Reset mid-period, with a simultaneous load that must be ignored.
        cfg(4, 0);
        step();
        step();
        rstn    = 1'b0;
        load    = 1'b1;
        divisor = 16'd5;
        step();
        check("midreset_bclk", int'(bclk), 1);
        check("midreset_ticks", int'(sample_tick) + int'(bit_tick) + int'(mid_bit_tick), 0);
        check("midreset_pending", int'(load_pending), 0);
        rstn = 1'b1;
        load = 1'b0;
        cnt  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            cnt += int'(sample_tick);
        end
        check("after_reset_stalled", cnt, 0);

        // Load while enabled but stalled: slot 0 two cycles after load.
        load    = 1'b1;
        divisor = 16'd4;
        step();
        load = 1'b0;
        check("stalled_load_pending", int'(load_pending), 1);
        step();
        check("stalled_load_applied", int'(load_pending), 0);
        measure(len, high);
        check("stalled_load_len", len, 4);
        check("stalled_load_high", high, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
